nrisc_multiciclo: RTL and testbench
===================================

NRISC_MULTICICLO -- requirements
Module: nrisc_multiciclo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register/data width (8..32).
REQ-002 SHALL have parameter ADDR_W, default 8, PC and data address width (6..16).
REQ-003 SHALL have port Clock  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port InstrReq  output  1  instruction fetch request.
REQ-006 SHALL have port InstrAddr  output  ADDR_W  fetch address (= PC).
REQ-007 SHALL have port InstrValid  input  1  fetch data valid, completes fetch handshake.
REQ-008 SHALL have port InstrData  input  8  instruction word.
REQ-009 SHALL have port DataReq  output  1  data access request.
REQ-010 SHALL have port DataWe  output  1  1 = store, 0 = load, meaningful only with DataReq.
REQ-011 SHALL have port DataAddr  output  ADDR_W  data address.
REQ-012 SHALL have port DataWdata  output  DATA_W  store data.
REQ-013 SHALL have port DataReady  input  1  completes data handshake.
REQ-014 SHALL have port DataRdata  input  DATA_W  load data, sampled when DataReq && DataReady.
REQ-015 SHALL have port PCOut  output  ADDR_W  current PC, debug.
REQ-016 SHALL have port InstrCount  output  32  retired-instruction counter, debug.

Function
REQ-017 SHALL decode InstrData as op=[7:6], a=[5:3], b=[2:0]; eight registers r0..r7 of DATA_W bits, none hardwired.
REQ-018 SHALL execute op 00 as ADD: r[a] <= r[a] + r[b], modulo 2^DATA_W; Z <= (result == 0).
REQ-019 SHALL execute op 01 as SUB: r[a] <= r[a] - r[b], modulo 2^DATA_W; Z <= (result == 0).
REQ-020 SHALL execute op 10 with a[2]=0 as LD: r{0,a[1:0]} <= mem[r[b]]; a[2]=1 as ST: mem[r[b]] <= r{0,a[1:0]}; Z unchanged.
REQ-021 SHALL form DataAddr from r[b] zero-extended or truncated to ADDR_W.
REQ-022 SHALL execute op 11 as BZ: if Z, PC <= PC + 1 + sext(InstrData[5:0]); else PC <= PC + 1; all PC arithmetic modulo 2^ADDR_W.
REQ-023 SHALL implement FSM states FETCH, EXEC, MEM; reset state FETCH.
REQ-024 FETCH SHALL hold InstrReq=1 with InstrAddr=PC stable until InstrValid; on that edge IR <= InstrData, go to EXEC.
REQ-025 EXEC (one cycle) SHALL, for ADD/SUB/BZ, write result/Z and PC at the closing edge and return to FETCH; for LD/ST, latch DataAddr/DataWe/DataWdata and go to MEM.
REQ-026 MEM SHALL hold DataReq=1 and all data outputs stable until DataReady; on that edge LD writes register, PC <= PC + 1, go to FETCH.
REQ-027 Minimum latency SHALL be 2 cycles for ADD/SUB/BZ, 3 for LD/ST; each wait cycle adds exactly one.
REQ-028 InstrCount SHALL increment by 1 on each retiring edge (EXEC exit to FETCH, or MEM completion), wrapping at 2^32.
REQ-029 InstrValid outside FETCH and DataReady outside MEM SHALL be ignored.
REQ-030 InstrReq and DataReq SHALL never be asserted in the same cycle.

Reset
REQ-031 Reset low SHALL immediately force: state FETCH, PC 0, Z 0, r0..r7 0, IR 0, InstrCount 0, InstrReq 1 after release only, DataReq 0, DataWe 0, DataAddr 0, DataWdata 0.
REQ-032 While Reset is low, InstrReq SHALL be 0; reset mid-handshake SHALL abandon the transaction with no register, PC or counter update.

Structure
REQ-033 Opcode constants, FSM state encoding and default widths SHALL live in shared package nrisc_pkg.
REQ-034 Register file SHALL be sub-module banco_registradores_p (DATA_W parameter, 2 async read ports, 1 sync write port, async active-low clear).

Verification
REQ-035 Reset release, InstrValid tied 1, program {ADD r1,r1 ; BZ +2}: PC 0->1->4, Z=1, InstrCount=2 after 4 cycles.
REQ-036 DATA_W=8, r1=0xFF, r2=0x01, SUB r2,r2 then ADD r1,... (r2 reloaded 0x01 via LD): r1 = 0x00, Z=1 (wrap).
REQ-037 LD r3,[r4] with r4=0x20, DataReady delayed 3 cycles, DataRdata=0xA5: DataReq high 4 cycles, DataAddr 0x20 stable, r3=0xA5, latency 6.
REQ-038 ST r2->[r5] with r2=0x3C, r5=0x10: DataWe=1, DataAddr=0x10, DataWdata=0x3C on the completing edge; Z unchanged.
REQ-039 BZ -1 at PC 0 with Z=1, ADDR_W=8: PC becomes 0x00 (PC+1-1); BZ -2 at PC 0: PC=0xFF wrap.
REQ-040 Reset asserted mid-MEM with DataReady 0: DataReq drops same cycle, after release PC=0, InstrCount=0, target register unchanged (0).

Source files
------------

// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared opcodes, FSM state encoding and default widths
package nrisc_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int NREGS = 8;
  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_LDST = 2'b10, OP_BZ = 2'b11} op_t;
endpackage

// File: rtl/banco_registradores_p.sv
// banco_registradores_p: eight-entry register file, two async reads, one sync write
module banco_registradores_p
  import nrisc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [2:0]        i_wa,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [2:0]        i_ra,
  input  logic [2:0]        i_rb,
  output logic [DATA_W-1:0] o_rda,
  output logic [DATA_W-1:0] o_rdb
);
  logic [DATA_W-1:0] r_regs [NREGS];
  // write port, cleared asynchronously on reset
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_regs <= '{default: '0};
    else if (i_we) r_regs[i_wa] <= i_wd;
  assign o_rda = r_regs[i_ra];
  assign o_rdb = r_regs[i_rb];
endmodule

// File: rtl/nrisc_multiciclo.sv
// nrisc_multiciclo: multicycle 8-bit-instruction RISC core with fetch/exec/mem FSM
module nrisc_multiciclo
  import nrisc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              InstrReq,
  output logic [ADDR_W-1:0] InstrAddr,
  input  logic              InstrValid,
  input  logic [7:0]        InstrData,
  output logic              DataReq,
  output logic              DataWe,
  output logic [ADDR_W-1:0] DataAddr,
  output logic [DATA_W-1:0] DataWdata,
  input  logic              DataReady,
  input  logic [DATA_W-1:0] DataRdata,
  output logic [ADDR_W-1:0] PCOut,
  output logic [31:0]       InstrCount
);
  state_t r_state, w_next;
  logic [7:0] r_ir;
  logic [ADDR_W-1:0] r_pc, w_pc1, w_br;
  logic r_z;
  op_t w_op;
  logic [2:0] w_a, w_b, w_ra, w_wa;
  logic [DATA_W-1:0] w_rda, w_rdb, w_alu, w_wd;
  logic w_ldst, w_alu_op, w_mem_done, w_retire, w_we;

  assign w_op = op_t'(r_ir[7:6]);
  assign w_a = r_ir[5:3];
  assign w_b = r_ir[2:0];
  assign w_ldst = w_op == OP_LDST;
  assign w_alu_op = w_op == OP_ADD || w_op == OP_SUB;
  // loads and stores only reach r0..r3 through the low two bits of a
  assign w_ra = w_ldst ? {1'b0, w_a[1:0]} : w_a;
  assign w_alu = w_op == OP_SUB ? w_rda - w_rdb : w_rda + w_rdb;
  assign w_mem_done = r_state == MEM && DataReady;
  assign w_retire = (r_state == EXEC && !w_ldst) || w_mem_done;
  assign w_we = (r_state == EXEC && w_alu_op) || (w_mem_done && !DataWe);
  assign w_wa = w_mem_done ? {1'b0, w_a[1:0]} : w_a;
  assign w_wd = w_mem_done ? DataRdata : w_alu;
  assign w_pc1 = r_pc + ADDR_W'(1);
  assign w_br = w_pc1 + ADDR_W'($signed(r_ir[5:0]));
  assign InstrAddr = r_pc;
  assign PCOut = r_pc;

  banco_registradores_p #(.DATA_W(DATA_W)) u_regs (
    .i_clk(Clock), .i_rst_n(Reset), .i_we(w_we), .i_wa(w_wa), .i_wd(w_wd),
    .i_ra(w_ra), .i_rb(w_b), .o_rda(w_rda), .o_rdb(w_rdb)
  );

  // FSM state register
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) r_state <= FETCH;
    else r_state <= w_next;

  // next state: wait on the fetch/data handshakes, memory ops take the MEM detour
  always_comb begin
    w_next = r_state == FETCH ? (InstrValid ? EXEC : FETCH) :
             r_state == EXEC  ? (w_ldst ? MEM : FETCH) :
             r_state == MEM   ? (DataReady ? FETCH : MEM) : FETCH;
  end

  // request strobes; fetch request is masked while reset is held
  always_comb begin
    InstrReq = Reset && r_state == FETCH;
    DataReq = r_state == MEM;
  end

  // datapath registers: IR, PC, Z flag, data-port latches and retire counter
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      r_ir <= '0;
      r_pc <= '0;
      r_z <= 1'b0;
      DataWe <= 1'b0;
      DataAddr <= '0;
      DataWdata <= '0;
      InstrCount <= '0;
    end else begin
      if (r_state == FETCH && InstrValid) r_ir <= InstrData;
      if (r_state == EXEC) begin
        if (w_ldst) begin
          DataWe <= w_a[2];
          DataAddr <= ADDR_W'(w_rdb);
          DataWdata <= w_rda;
        end else if (w_op == OP_BZ) r_pc <= r_z ? w_br : w_pc1;
        else begin
          r_pc <= w_pc1;
          r_z <= w_alu == '0;
        end
      end
      if (w_mem_done) r_pc <= w_pc1;
      if (w_retire) InstrCount <= InstrCount + 32'd1;
    end
endmodule

// File: tb/tb_nrisc_multiciclo.sv
// tb_nrisc_multiciclo: ISA reference model plus scoreboard of expected data-port transactions
module tb_nrisc_multiciclo;
  logic Clock = 1'b0, Reset = 1'b1;
  logic InstrReq, InstrValid = 1'b0, DataReq, DataWe, DataReady = 1'b0;
  logic [7:0] InstrAddr, InstrData = '0, DataAddr, DataWdata, DataRdata = '0, PCOut;
  logic [31:0] InstrCount;

  typedef struct packed {logic we; logic [7:0] addr; logic [7:0] wdata;} txn_t;
  txn_t exp_q[$];
  int errors = 0, checks = 0;
  logic [7:0] m_r [8];
  logic m_z;
  logic [7:0] m_pc;
  logic [31:0] m_cnt;
  logic tie = 1'b0;

  nrisc_multiciclo #(.DATA_W(8), .ADDR_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .InstrReq(InstrReq), .InstrAddr(InstrAddr),
    .InstrValid(InstrValid), .InstrData(InstrData), .DataReq(DataReq), .DataWe(DataWe),
    .DataAddr(DataAddr), .DataWdata(DataWdata), .DataReady(DataReady), .DataRdata(DataRdata),
    .PCOut(PCOut), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b0;
    InstrValid = 1'b0;
    DataReady = 1'b0;
    tie = 1'b0;
    #1;
    chk("rst_ireq", InstrReq, 0);
    chk("rst_dreq", DataReq, 0);
    chk("rst_pc", PCOut, 0);
    chk("rst_cnt", InstrCount, 0);
    chk("rst_dwe", DataWe, 0);
    chk("rst_daddr", DataAddr, 0);
    cyc;
    chk("rst_hold_ireq", InstrReq, 0);
    Reset = 1'b1;
    #1;
    chk("rel_ireq", InstrReq, 1);
    foreach (m_r[i]) m_r[i] = '0;
    m_z = 1'b0;
    m_pc = '0;
    m_cnt = '0;
    exp_q.delete();
  endtask

  task automatic issue(input logic [7:0] ins, input int iw, input int dw, input logic [7:0] ld);
    logic [1:0] op;
    logic [2:0] a, b;
    logic [7:0] res;
    txn_t t;
    int n;
    op = ins[7:6];
    a = ins[5:3];
    b = ins[2:0];
    n = 0;
    while (!InstrReq && n < 20) begin
      cyc;
      n++;
    end
    chk("ireq_wait", InstrReq, 1);
    chk("iaddr", InstrAddr, m_pc);
    InstrData = ins;
    repeat (iw) begin
      InstrValid = 1'b0;
      cyc;
      chk("ireq_hold", InstrReq, 1);
      chk("iaddr_hold", InstrAddr, m_pc);
    end
    InstrValid = 1'b1;
    cyc;
    if (tie) InstrData = 8'hFF;
    else InstrValid = 1'b0;
    chk("exec_ireq", InstrReq, 0);
    chk("exec_dreq", DataReq, 0);
    if (op == 2'b10) begin
      t.we = a[2];
      t.addr = m_r[b];
      t.wdata = m_r[{1'b0, a[1:0]}];
      exp_q.push_back(t);
      cyc;
      chk("dreq", DataReq, 1);
      chk("mem_ireq", InstrReq, 0);
      if (exp_q.size() > 0) t = exp_q.pop_front();
      chk("dwe", DataWe, t.we);
      chk("daddr", DataAddr, t.addr);
      if (t.we) chk("dwdata", DataWdata, t.wdata);
      repeat (dw) begin
        DataReady = 1'b0;
        cyc;
        chk("dreq_hold", DataReq, 1);
        chk("daddr_hold", DataAddr, t.addr);
        chk("dwe_hold", DataWe, t.we);
        if (t.we) chk("dwdata_hold", DataWdata, t.wdata);
      end
      DataRdata = ld;
      DataReady = 1'b1;
      cyc;
      DataReady = 1'b0;
      if (!a[2]) m_r[{1'b0, a[1:0]}] = ld;
      m_pc = m_pc + 8'd1;
    end else begin
      cyc;
      if (op == 2'b11) m_pc = m_z ? m_pc + 8'd1 + {{2{ins[5]}}, ins[5:0]} : m_pc + 8'd1;
      else begin
        res = op == 2'b00 ? m_r[a] + m_r[b] : m_r[a] - m_r[b];
        m_r[a] = res;
        m_z = res == 8'd0;
        m_pc = m_pc + 8'd1;
      end
    end
    m_cnt++;
    chk("pc", PCOut, m_pc);
    chk("cnt", InstrCount, m_cnt);
    chk("back_fetch", InstrReq, 1);
    chk("fetch_dreq", DataReq, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ins;
    #3;
    do_reset;
    // ADD r1,r1 ; BZ +2 with InstrValid held high
    tie = 1'b1;
    InstrValid = 1'b1;
    issue(8'h09, 0, 0, 8'h00);
    issue(8'hC2, 0, 0, 8'h00);
    tie = 1'b0;
    InstrValid = 1'b0;
    chk("t1_pc", PCOut, 8'h04);
    chk("t1_cnt", InstrCount, 2);
    // subtract to zero, reload, wrap-around add, observe via store and branch
    issue(8'h88, 1, 0, 8'hFF);
    issue(8'h90, 0, 1, 8'h01);
    issue(8'h52, 0, 0, 8'h00);
    issue(8'h90, 0, 0, 8'h01);
    issue(8'h0A, 0, 0, 8'h00);
    issue(8'hA8, 0, 0, 8'h00);
    issue(8'hC1, 0, 0, 8'h00);
    // LD r3,[r4] with r4=0x20 and a delayed DataReady
    issue(8'h98, 0, 0, 8'h20);
    issue(8'h23, 0, 0, 8'h00);
    issue(8'h9C, 0, 3, 8'hA5);
    issue(8'hB8, 0, 0, 8'h00);
    // ST r2->[r5], Z preserved across the store
    issue(8'h90, 0, 0, 8'h3C);
    issue(8'h98, 0, 0, 8'h10);
    issue(8'h2B, 0, 0, 8'h00);
    issue(8'hB5, 0, 2, 8'h00);
    issue(8'hC3, 0, 0, 8'h00);
    issue(8'h76, 0, 0, 8'h00);
    issue(8'hB5, 1, 0, 8'h00);
    issue(8'hC3, 0, 0, 8'h00);
    // backward branches and PC wrap
    do_reset;
    issue(8'h00, 0, 0, 8'h00);
    issue(8'hFE, 0, 0, 8'h00);
    chk("t5_pc0", PCOut, 8'h00);
    issue(8'hFE, 0, 0, 8'h00);
    chk("t5_wrap", PCOut, 8'hFF);
    issue(8'hFF, 0, 0, 8'h00);
    issue(8'hC1, 0, 0, 8'h00);
    chk("t5_fwd_wrap", PCOut, 8'h01);
    // reset in the middle of a load
    do_reset;
    issue(8'h98, 0, 0, 8'h20);
    issue(8'h23, 0, 0, 8'h00);
    do_reset;
    InstrData = 8'h9C;
    InstrValid = 1'b1;
    cyc;
    InstrValid = 1'b0;
    cyc;
    chk("t6_dreq", DataReq, 1);
    DataRdata = 8'h77;
    cyc;
    Reset = 1'b0;
    #1;
    chk("t6_drop", DataReq, 0);
    chk("t6_pc", PCOut, 0);
    chk("t6_cnt", InstrCount, 0);
    do_reset;
    issue(8'hB8, 0, 0, 8'h00);
    // random mix with random handshake delays
    for (int i = 0; i < 40; i++) begin
      ins = 8'($urandom);
      issue(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 8'($urandom));
    end
    chk("q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
